fsqrt_round_pack: RTL and testbench

- Downstream stage of the 24-bit Newton–Raphson square-root core.
- Carries the fsqrt side-band (sign, operand class, result exponent, rounding mode) down a delay line that matches the core's id→e1→e2→e3 result pipeline.
- Rounds the core's 32-bit root q (.1xxx…x, LSB = sticky OR) to 24 bits and packs an IEEE-754 single result plus exception flags into a write-back register.

---
 rtl/fsqrt_round_pack.sv | 149 ++++++++++++++
 tb/tb_fsqrt_round_pack.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/fsqrt_round_pack.sv
// fsqrt_round_pack
//   Final stage of the 24-bit Newton-Raphson square-root unit. The fsqrt
//   side-band (sign, operand class, result exponent, rounding mode) rides a
//   three-stage delay line (e1/e2/e3). This keeps it aligned with the root
//   core's id->e1->e2->e3 result pipeline. In e3 the side-band meets the
//   core's root q. The root is rounded to 24 bits, packed as an IEEE-754
//   single, and registered together with the exception flags.
//
// Ports
//   clk, clrn        clock, asynchronous active-low reset
//   ena              pipeline enable (shared with the root core)
//   cancel           kills every in-flight entry (valid bits only)
//   id_valid         an fsqrt result issues from ID this enabled cycle
//   id_sign/cls/exp/rm  side-band captured at issue
//   q                root from core e3: q[31:8] mantissa, q[7] guard,
//                    q[6:0] round/sticky
//   res, res_valid   packed result, valid for one enabled cycle per entry
//   flags            {NV,DZ,OF,UF,NX}
//
// Build option
//   FSQRT_FLAGS_EN   when defined, NV/NX are produced. When undefined,
//                    flags is tied to zero and the flag logic is not built.
module fsqrt_round_pack #(
    parameter logic [31:0] QNAN = 32'h7fc00000
) (
    input  logic        clk,
    input  logic        clrn,
    input  logic        ena,
    input  logic        cancel,
    input  logic        id_valid,
    input  logic        id_sign,
    input  logic [2:0]  id_cls,
    input  logic [7:0]  id_exp,
    input  logic [1:0]  id_rm,
    input  logic [31:0] q,
    output logic [31:0] res,
    output logic        res_valid,
    output logic [4:0]  flags
);
    localparam logic [2:0] CLS_NORM = 3'b000;
    localparam logic [2:0] CLS_ZERO = 3'b001;
    localparam logic [2:0] CLS_PINF = 3'b010;
    localparam logic [2:0] CLS_QNAN = 3'b011;
    localparam logic [2:0] CLS_SNAN = 3'b100;

    localparam logic [1:0] RM_RNE = 2'b00;
    localparam logic [1:0] RM_RUP = 2'b11;

    // Side-band delay line; index 1..3 = e1..e3
    logic [3:1]       vld_pipe;
    logic [3:1]       sign_p;
    logic [3:1][2:0]  cls_p;
    logic [3:1][7:0]  exp_p;
    logic [3:1][1:0]  rm_p;

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            vld_pipe <= '0;
            sign_p   <= '0;
            cls_p    <= '0;
            exp_p    <= '0;
            rm_p     <= '0;
        end else begin
            if (ena) begin
                vld_pipe <= {vld_pipe[2:1], id_valid};
                sign_p   <= {sign_p[2:1], id_sign};
                cls_p    <= {cls_p[2:1], id_cls};
                exp_p    <= {exp_p[2:1], id_exp};
                rm_p     <= {rm_p[2:1], id_rm};
            end
            // cancel clears valid bits whether or not the pipe advances
            if (cancel)
                vld_pipe <= '0;
        end
    end

    // Rounding of the e3 entry against the core's root
    logic [23:0] m;
    logic        g, s, inc;
    logic [24:0] m25;
    logic [7:0]  exp_r;
    logic [22:0] frac_r;
    logic [31:0] res_nxt;
    logic [4:0]  fl_nxt;

    always_comb begin
        m = q[31:8];
        g = q[7];
        s = |q[6:0];
        case (rm_p[3])
            RM_RNE:  inc = g & (s | m[0]);
            RM_RUP:  inc = g | s;
            default: inc = 1'b0;          // RZ and RDN (result is positive)
        endcase
        m25 = {1'b0, m} + {24'd0, inc};
        // Carry out of 24'hffffff renormalises to 1.0 with exponent + 1;
        // the exponent cannot wrap because it is at most 253 upstream.
        if (m25[24]) begin
            exp_r  = exp_p[3] + 8'd1;
            frac_r = 23'd0;
        end else begin
            exp_r  = exp_p[3];
            frac_r = m25[22:0];
        end

        case (cls_p[3])
            CLS_NORM: res_nxt = {1'b0, exp_r, frac_r};
            CLS_ZERO: res_nxt = {sign_p[3], 31'd0};
            CLS_PINF: res_nxt = 32'h7f800000;
            default:  res_nxt = QNAN;     // qNaN, sNaN, negative operand
        endcase
    end

`ifdef FSQRT_FLAGS_EN
    logic nv, nx;
    always_comb begin
        // Anything outside normal/zero/+inf/qNaN is an invalid operation
        nv = (cls_p[3] != CLS_NORM) && (cls_p[3] != CLS_ZERO) &&
             (cls_p[3] != CLS_PINF) && (cls_p[3] != CLS_QNAN);
        nx = (cls_p[3] == CLS_NORM) && (g | s);
        fl_nxt = {nv, 3'b000, nx};
    end
`else
    assign fl_nxt = 5'b0;
`endif

    // Write-back register
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            res       <= '0;
            res_valid <= 1'b0;
            flags     <= '0;
        end else if (cancel) begin
            res_valid <= 1'b0;
            if (ena) begin
                res   <= '0;
                flags <= '0;
            end
        end else if (ena) begin
            res_valid <= vld_pipe[3];
            res       <= vld_pipe[3] ? res_nxt : 32'd0;
            flags     <= vld_pipe[3] ? fl_nxt  : 5'd0;
        end
    end

    // Kept as a named constant for readers matching class encodings
    logic unused_snan;
    assign unused_snan = (CLS_SNAN == 3'b100);
endmodule

// File: tb/tb_fsqrt_round_pack.sv
module tb_fsqrt_round_pack;
`ifdef FSQRT_FLAGS_EN
    localparam bit FL_EN = 1'b1;
`else
    localparam bit FL_EN = 1'b0;
`endif

    logic        clk = 0, clrn = 0, ena = 0, cancel = 0, id_valid = 0, id_sign = 0;
    logic [2:0]  id_cls = 0;
    logic [7:0]  id_exp = 0;
    logic [1:0]  id_rm = 0;
    logic [31:0] q = 0;
    logic [31:0] res;
    logic        res_valid;
    logic [4:0]  flags;

    int n_chk = 0, n_fail = 0;

    fsqrt_round_pack dut (
        .clk(clk), .clrn(clrn), .ena(ena), .cancel(cancel),
        .id_valid(id_valid), .id_sign(id_sign), .id_cls(id_cls),
        .id_exp(id_exp), .id_rm(id_rm), .q(q),
        .res(res), .res_valid(res_valid), .flags(flags)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    typedef struct {
        logic       sign;
        logic [2:0] cls;
        logic [7:0] exp;
        logic [1:0] rm;
        int         age;   // enabled edges seen since issue
    } entry_t;

    entry_t     inflight[$];
    logic       exp_valid = 0;
    logic [31:0] exp_res = 0;
    logic [4:0]  exp_flags = 0;

    // Rounds the root by comparing the discarded byte against one half.
    function automatic logic [36:0] model(input logic sign, input logic [2:0] cls,
                                          input logic [7:0] e, input logic [1:0] rm,
                                          input logic [31:0] qq);
        int unsigned mant, rem, ex;
        logic up;
        logic [4:0] f;
        f = 5'd0;
        case (cls)
            3'd0: begin
                mant = qq >> 8;
                rem  = qq & 32'hff;
                ex   = e;
                case (rm)
                    2'd0: up = (rem > 128) || (rem == 128 && (mant % 2) == 1);
                    2'd3: up = (rem != 0);
                    default: up = 0;
                endcase
                if (up) mant = mant + 1;
                if (mant == (1 << 24)) begin mant = mant / 2; ex = ex + 1; end
                if (rem != 0) f[0] = 1'b1;
                return {(FL_EN ? f : 5'd0), 1'b0, ex[7:0], mant[22:0]};
            end
            3'd1: return {5'd0, sign, 31'd0};
            3'd2: return {5'd0, 32'h7f800000};
            3'd3: return {5'd0, 32'h7fc00000};
            default: return {(FL_EN ? 5'b10000 : 5'd0), 32'h7fc00000};
        endcase
    endfunction

    always @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            inflight.delete();
            exp_valid = 0;
        end else if (cancel) begin
            inflight.delete();
            exp_valid = 0;
        end else if (ena) begin
            logic [36:0] r;
            exp_valid = 0;
            if (inflight.size() > 0 && inflight[0].age == 2) begin
                r = model(inflight[0].sign, inflight[0].cls, inflight[0].exp,
                          inflight[0].rm, q);
                exp_res   = r[31:0];
                exp_flags = r[36:32];
                exp_valid = 1;
                void'(inflight.pop_front());
            end
            foreach (inflight[i]) inflight[i].age++;
            if (id_valid) begin
                entry_t e;
                e.sign = id_sign; e.cls = id_cls; e.exp = id_exp; e.rm = id_rm; e.age = 0;
                inflight.push_back(e);
            end
        end
    end

    // Compare process: every cycle outside reset
    always @(negedge clk) begin
        if (clrn) begin
            n_chk++;
            if (res_valid !== exp_valid) begin
                n_fail++;
                $display("FAIL model_valid t=%0t: got %b expected %b", $time, res_valid, exp_valid);
            end else if (exp_valid) begin
                n_chk++;
                if (res !== exp_res || flags !== exp_flags) begin
                    n_fail++;
                    $display("FAIL model_res t=%0t: got %h/%b expected %h/%b",
                             $time, res, flags, exp_res, exp_flags);
                end
            end
            if (!FL_EN) begin
                n_chk++;
                if (flags !== 5'd0) begin
                    n_fail++;
                    $display("FAIL flags_off: got %b expected 00000", flags);
                end
            end
        end
    end

    // ---------------- directed helpers ----------------
    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        n_chk++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, expv);
        end
    endtask

    task automatic issue(input logic [2:0] c, input logic sg, input logic [7:0] e,
                         input logic [1:0] r, input logic [31:0] qq);
        @(negedge clk);
        ena = 1; cancel = 0; id_valid = 1;
        id_cls = c; id_sign = sg; id_exp = e; id_rm = r; q = qq;
        @(negedge clk);            // edge k taken
        id_valid = 0;
    endtask

    task automatic run_dir(input string nm, input logic [2:0] c, input logic sg,
                           input logic [7:0] e, input logic [1:0] r, input logic [31:0] qq,
                           input logic [31:0] er, input logic [4:0] ef);
        issue(c, sg, e, r, qq);
        repeat (2) @(negedge clk); // after edge k+2
        chk({nm, "_early"}, res_valid, 1'b0);
        @(negedge clk);            // after edge k+3
        chk({nm, "_valid"}, res_valid, 1'b1);
        chk({nm, "_res"}, res, er);
        chk({nm, "_flags"}, flags, FL_EN ? ef : 5'd0);
        @(negedge clk);
        chk({nm, "_once"}, res_valid, 1'b0);
    endtask

    task automatic never_valid(input string nm, input int n);
        int seen = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (res_valid) seen++;
        end
        chk(nm, seen, 0);
    endtask

    initial begin
        #12;
        chk("reset_res", res, 0);
        chk("reset_valid", res_valid, 0);
        chk("reset_flags", flags, 0);
        @(negedge clk); clrn = 1;
        ena = 1;
        repeat (2) @(negedge clk);

        run_dir("sqrt4",    3'd0, 0, 8'd128, 2'd0, 32'h80000000, 32'h40000000, 5'b00000);
        run_dir("sqrt2rne", 3'd0, 0, 8'd127, 2'd0, 32'hb504f333, 32'h3fb504f3, 5'b00001);
        run_dir("sqrt2rup", 3'd0, 0, 8'd127, 2'd3, 32'hb504f333, 32'h3fb504f4, 5'b00001);
        run_dir("sqrt2rz",  3'd0, 0, 8'd127, 2'd1, 32'hb504f333, 32'h3fb504f3, 5'b00001);
        run_dir("carry",    3'd0, 0, 8'd127, 2'd0, 32'hffffff80, 32'h40000000, 5'b00001);
        run_dir("neg",      3'd5, 1, 8'd0,   2'd0, 32'h12345678, 32'h7fc00000, 5'b10000);
        run_dir("snan",     3'd4, 0, 8'd0,   2'd0, 32'hffffffff, 32'h7fc00000, 5'b10000);
        run_dir("qnan",     3'd3, 0, 8'd0,   2'd0, 32'hffffffff, 32'h7fc00000, 5'b00000);
        run_dir("negzero",  3'd1, 1, 8'd0,   2'd0, 32'hffffffff, 32'h80000000, 5'b00000);
        run_dir("pinf",     3'd2, 0, 8'd0,   2'd3, 32'hffffffff, 32'h7f800000, 5'b00000);

        // Stall: after edge k+1 hold ena low for 5 cycles
        issue(3'd0, 0, 8'd127, 2'd0, 32'hb504f333);
        @(negedge clk);            // edge k+1 taken
        ena = 0;
        repeat (5) begin
            @(negedge clk);
            chk("stall_frozen", {res_valid, res}, {1'b0, 32'h0});
        end
        ena = 1;
        @(negedge clk);            // k+2
        chk("stall_early", res_valid, 1'b0);
        @(negedge clk);            // k+3
        chk("stall_valid", res_valid, 1'b1);
        chk("stall_res", res, 32'h3fb504f3);

        // Cancel one cycle after issue
        issue(3'd0, 0, 8'd100, 2'd0, 32'h90000000);
        cancel = 1;
        @(negedge clk);
        cancel = 0;
        never_valid("cancel_never", 6);

        // Reset pulse with the entry in e2
        issue(3'd0, 0, 8'd100, 2'd0, 32'h90000000);
        @(negedge clk);            // k+1: entry in e2
        #2 clrn = 0;
        #2 clrn = 1;
        never_valid("reset_never", 6);
        run_dir("after_rst", 3'd0, 0, 8'd128, 2'd0, 32'h80000000, 32'h40000000, 5'b00000);

        // Randomised traffic checked by the model
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            ena      = ($urandom_range(0, 3) != 0);
            cancel   = ($urandom_range(0, 40) == 0);
            id_valid = $urandom_range(0, 1);
            id_sign  = $urandom_range(0, 1);
            id_cls   = $urandom_range(0, 3) == 0 ? 3'($urandom_range(1, 5)) : 3'd0;
            id_exp   = 8'($urandom_range(0, 253));
            id_rm    = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 3))
                0: q = {24'hffffff, 8'($urandom)};
                1: q = {1'b1, 23'($urandom), 8'h80};
                default: q = {1'b1, 31'($urandom)};
            endcase
        end
        @(negedge clk);
        ena = 1; cancel = 0; id_valid = 0;
        repeat (6) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
